// File: rtl/ysyx_22040386_mdu_ctrl_if.sv
// Request/response bundle between the pipeline and the iterative multiply/divide unit.
interface ysyx_22040386_mdu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        sign_op;
    logic        word_op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output in_valid, op, sign_op, word_op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, sign_op, word_op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22040386_mdu_ctrl.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle bypass for divide-by-zero and overflow.
module ysyx_22040386_mdu_ctrl (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22040386_mdu_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_mul;
    logic        r_rem;
    logic        r_word;
    logic        r_negq;
    logic        r_negr;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_acc;
    logic [63:0] r_result;
    logic        r_out_valid;

    logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_byp;
    logic        w_is_div, w_is_rem, w_div0, w_ovf;
    logic [63:0] w_acc_mul, w_rem_n, w_quo_n, w_q, w_qs, w_rs, w_sel, w_final;
    logic [64:0] w_shift, w_diff;
    logic        w_qbit;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    // Operand preparation and the bypass cases, evaluated on the request.
    always_comb begin
        w_a_ext = bus.src1;
        w_b_ext = bus.src2;
        if (bus.word_op) begin
            w_a_ext = {{32{bus.sign_op & bus.src1[31]}}, bus.src1[31:0]};
            w_b_ext = {{32{bus.sign_op & bus.src2[31]}}, bus.src2[31:0]};
        end
        w_a_mag  = (bus.sign_op && w_a_ext[63]) ? -w_a_ext : w_a_ext;
        w_b_mag  = (bus.sign_op && w_b_ext[63]) ? -w_b_ext : w_b_ext;
        w_is_div = (bus.op == 2'b01);
        w_is_rem = (bus.op == 2'b10);
        w_min    = bus.word_op ? 64'hFFFF_FFFF_8000_0000
                               : 64'h8000_0000_0000_0000;
        w_div0   = (w_b_ext == 64'd0);
        w_ovf    = bus.sign_op && (w_a_ext == w_min) && (w_b_ext == '1);
        w_byp    = 64'd0;
        if (w_is_div)
            w_byp = w_div0 ? '1 : w_a_ext;
        else if (w_div0)
            w_byp = bus.word_op ? {{32{bus.src1[31]}}, bus.src1[31:0]}
                                : bus.src1;
    end

    // One iteration step plus the sign/width fix-up of the final value.
    always_comb begin
        w_acc_mul = r_acc + (r_b[0] ? r_a : 64'd0);
        w_shift   = {r_acc, r_a[63]};
        w_diff    = w_shift - {1'b0, r_b};
        w_qbit    = ~w_diff[64];
        w_rem_n   = w_qbit ? w_diff[63:0] : w_shift[63:0];
        w_quo_n   = {r_a[62:0], w_qbit};
        w_q       = r_word ? {32'd0, w_quo_n[31:0]} : w_quo_n;
        w_qs      = r_negq ? -w_q : w_q;
        w_rs      = r_negr ? -w_rem_n : w_rem_n;
        w_sel     = r_mul ? w_acc_mul : (r_rem ? w_rs : w_qs);
        w_final   = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_mul       <= 1'b0;
            r_rem       <= 1'b0;
            r_word      <= 1'b0;
            r_negq      <= 1'b0;
            r_negr      <= 1'b0;
            r_a         <= 64'd0;
            r_b         <= 64'd0;
            r_acc       <= 64'd0;
            r_result    <= 64'd0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= 64'd0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_mul  <= !(w_is_div || w_is_rem);
                    r_rem  <= w_is_rem;
                    r_word <= bus.word_op;
                    r_negq <= bus.sign_op && (w_a_ext[63] ^ w_b_ext[63]);
                    r_negr <= bus.sign_op && w_a_ext[63];
                    r_acc  <= 64'd0;
                    r_cnt  <= bus.word_op ? 6'd31 : 6'd63;
                    if ((w_is_div || w_is_rem) && (w_div0 || w_ovf)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_byp;
                    end else if (w_is_div || w_is_rem) begin
                        r_state <= CALC;
                        r_a     <= bus.word_op ? {w_a_mag[31:0], 32'd0}
                                               : w_a_mag;
                        r_b     <= w_b_mag;
                    end else begin
                        r_state <= CALC;
                        r_a     <= w_a_ext;
                        r_b     <= w_b_ext;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_mul) begin
                        r_acc <= w_acc_mul;
                        r_a   <= {r_a[62:0], 1'b0};
                        r_b   <= {1'b0, r_b[63:1]};
                    end else begin
                        r_acc <= w_rem_n;
                        r_a   <= w_quo_n;
                    end
                    if (r_cnt == 6'd0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_final;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040386_mdu_ctrl.sv
// Directed + random bench for the multiply/divide controller with a
// result/latency scoreboard and an arithmetic reference model.
module tb_ysyx_22040386_mdu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    ysyx_22040386_mdu_ctrl_if ifc ();

    ysyx_22040386_mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    task automatic model(input logic [1:0] op, input logic sg, input logic wd,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        logic [63:0]        p, q, r;
        logic [31:0]        a32, b32, q32, r32;
        logic signed [31:0] sa32, sb32, sq32, sr32;
        logic signed [63:0] sa, sb, sq, sr;
        a32 = a[31:0];
        b32 = b[31:0];
        lat = wd ? 33 : 65;
        if (op != 2'b01 && op != 2'b10) begin
            p   = a * b;
            res = wd ? sx(p[31:0]) : p;
            return;
        end
        if (wd) begin
            if (b32 == 32'd0) begin
                q = '1; r = sx(a32); lat = 1;
            end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q = sx(a32); r = 64'd0; lat = 1;
            end else if (sg) begin
                sa32 = a32; sb32 = b32;
                sq32 = sa32 / sb32; sr32 = sa32 % sb32;
                q = sx(sq32); r = sx(sr32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
                q = sx(q32); r = sx(r32);
            end
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0; lat = 1;
            end else if (sg) begin
                sa = a; sb = b;
                sq = sa / sb; sr = sa % sb;
                q = sq; r = sr;
            end else begin
                q = a / b; r = a % b;
            end
        end
        res = (op == 2'b01) ? q : r;
    endtask

    // Issue one request, scramble inputs during CALC, then check the output.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic sg, input logic wd,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic use_const, input logic [63:0] cres,
                         input int clat);
        exp_t e;
        int   n;
        if (use_const) begin
            e.res = cres; e.lat = clat;
        end else begin
            model(op, sg, wd, a, b, e.res, e.lat);
        end
        sb_q.push_back(e);
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.op = op; ifc.sign_op = sg; ifc.word_op = wd;
        ifc.src1 = a; ifc.src2 = b; ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.src1 = {$urandom, $urandom}; ifc.src2 = {$urandom, $urandom};
        ifc.op = 2'($urandom); ifc.sign_op = ~sg; ifc.word_op = ~wd;
        n = 1;
        while (!ifc.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        e = sb_q.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({tag, "_res"}, ifc.result, e.res);
        chk({tag, "_rdy_done"}, 64'(ifc.in_ready), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_rdy_after"}, 64'(ifc.in_ready), 64'd1);
        chk({tag, "_ov_after"}, 64'(ifc.out_valid), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   seen;
        logic [1:0]  rop;
        logic [63:0] ra, rb;

        ifc.in_valid = 1'b1; ifc.op = 2'b00; ifc.sign_op = 1'b0;
        ifc.word_op = 1'b0; ifc.src1 = 64'd3; ifc.src2 = 64'd4;
        ifc.flush = 1'b0; ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", 64'(ifc.out_valid), 64'd0);
        chk("rst_res", ifc.result, 64'd0);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_rdy", 64'(ifc.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; ifc.in_valid = 1'b0;

        do_op("mul_7x-3", 2'b00, 1'b0, 1'b0, 64'd7, -64'sd3,
              1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        do_op("divw_s", 2'b01, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        do_op("remw_s", 2'b10, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        do_op("div_z", 2'b01, 1'b0, 1'b0, 64'd123, 64'd0,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("rem_z", 2'b10, 1'b0, 1'b0, 64'd5, 64'd0, 1'b1, 64'd5, 1);
        do_op("div_ovf", 2'b01, 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1,
              1'b1, 64'h8000_0000_0000_0000, 1);
        do_op("rem_ovf", 2'b10, 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1,
              1'b1, 64'd0, 1);
        do_op("divw_z", 2'b01, 1'b1, 1'b1, 64'd9, 64'hABCD_0000_0000_0000,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remw_z", 2'b10, 1'b0, 1'b1, 64'h0000_0000_8000_0001, 64'd0,
              1'b1, 64'hFFFF_FFFF_8000_0001, 1);
        do_op("divw_ovf", 2'b01, 1'b1, 1'b1, 64'h0000_0000_8000_0000,
              64'h0000_0000_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
        do_op("op11_mul", 2'b11, 1'b1, 1'b0, 64'd6, 64'd7, 1'b1, 64'd42, 65);
        do_op("mulw", 2'b00, 1'b0, 1'b1, 64'h0000_0001_0001_0000,
              64'h0000_0000_0001_0000, 1'b1, 64'd0, 33);
        do_op("div_s", 2'b01, 1'b1, 1'b0, -64'sd100, 64'd7,
              1'b1, -64'sd14, 65);
        do_op("rem_s", 2'b10, 1'b1, 1'b0, -64'sd100, 64'd7,
              1'b1, -64'sd2, 65);
        do_op("divu", 2'b01, 1'b0, 1'b0, '1, 64'd3,
              1'b1, 64'h5555_5555_5555_5555, 65);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = (i % 4 == 0) ? 64'($urandom_range(1, 300)) : {$urandom, $urandom};
            if (i % 3 == 0) ra = 64'($signed($urandom_range(0, 100000)) - 50000);
            do_op("rand", rop, 1'($urandom), 1'($urandom), ra, rb,
                  1'b0, 64'd0, 0);
        end

        // Backpressure hold, then flush out of DONE.
        e.res = 64'd14; e.lat = 65;
        sb_q.push_back(e);
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.op = 2'b01; ifc.sign_op = 1'b0;
        ifc.word_op = 1'b0; ifc.src1 = 64'd100; ifc.src2 = 64'd7;
        ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        n = 1;
        while (!ifc.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        e = sb_q.pop_front();
        chk("bp_lat", 64'(n), 64'(e.lat));
        for (int i = 0; i < 10; i++) begin
            ifc.src1 = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("bp_res", ifc.result, e.res);
            chk("bp_ov", 64'(ifc.out_valid), 64'd1);
            chk("bp_rdy", 64'(ifc.in_ready), 64'd0);
        end
        @(negedge clk);
        ifc.flush = 1'b1; ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        chk("fl_done_ov", 64'(ifc.out_valid), 64'd0);
        chk("fl_done_rdy", 64'(ifc.in_ready), 64'd1);

        // Flush together with a request must not accept it.
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0; ifc.flush = 1'b0;
        chk("fl_req_busy", 64'(ifc.busy), 64'd0);
        chk("fl_req_rdy", 64'(ifc.in_ready), 64'd1);

        // Flush during CALC.
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.op = 2'b00; ifc.src1 = 64'd5; ifc.src2 = 64'd5;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        chk("fl_calc_busy", 64'(ifc.busy), 64'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        chk("fl_calc_rdy", 64'(ifc.in_ready), 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (ifc.out_valid) seen++;
        end
        chk("fl_calc_noov", 64'(seen), 64'd0);

        // Reset at CALC cycle 20.
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.op = 2'b00; ifc.src1 = 64'd9; ifc.src2 = 64'd9;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; ifc.in_valid = 1'b1; ifc.flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ifc.in_valid = 1'b0; ifc.flush = 1'b0;
        chk("rst_calc_rdy", 64'(ifc.in_ready), 64'd1);
        chk("rst_calc_res", ifc.result, 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (ifc.out_valid) seen++;
        end
        chk("rst_calc_noov", 64'(seen), 64'd0);

        do_op("post_rst", 2'b10, 1'b0, 1'b0, 64'd1000, 64'd33,
              1'b1, 64'd10, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
